// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed active-low 7-segment display bus plus the decoded frame it produces.
// master drives the display pins and observes the frame; slave is the decoder.
interface seg7_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 8
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    frame_valid;
  logic                    frame_err;
  logic [NUM_DIGITS-1:0]   invalid_mask;

  modport master (
    output seg_n, an_n,
    input  value, frame_valid, frame_err, invalid_mask
  );

  modport slave (
    input  seg_n, an_n,
    output value, frame_valid, frame_err, invalid_mask
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, decodes each stable digit back to hex
// and publishes a whole scan frame at once once every digit has been captured.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_decoder_if.slave bus
);
  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StCaptured} state_e;

  state_e                  state_q;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [NUM_DIGITS+6:0]   prev_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   bitmap_q, bitmap_d, stage_inv_q, invalid_mask_q;
  logic [4*NUM_DIGITS-1:0] stage_val_q, value_q;
  logic                    frame_valid_q, frame_err_q;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    sel_ok, changed, capture, frame_done, dec_inv;
  logic [3:0]              dec_nib;

  always_comb begin
    dec_nib = 4'h0;
    dec_inv = 1'b0;
    case (seg_q)
      7'h40:   dec_nib = 4'h0;
      7'h79:   dec_nib = 4'h1;
      7'h24:   dec_nib = 4'h2;
      7'h30:   dec_nib = 4'h3;
      7'h19:   dec_nib = 4'h4;
      7'h12:   dec_nib = 4'h5;
      7'h02:   dec_nib = 4'h6;
      7'h78:   dec_nib = 4'h7;
      7'h00:   dec_nib = 4'h8;
      7'h10:   dec_nib = 4'h9;
      7'h08:   dec_nib = 4'hA;
      7'h03:   dec_nib = 4'hB;
      7'h46:   dec_nib = 4'hC;
      7'h21:   dec_nib = 4'hD;
      7'h06:   dec_nib = 4'hE;
      7'h0E:   dec_nib = 4'hF;
      default: dec_inv = 1'b1;
    endcase
  end

  always_comb begin
    sel     = ~an_q;
    sel_ok  = ($countones(sel) == 1);
    changed = ({an_q, seg_q} != prev_q);
    if (!sel_ok) begin
      cnt_d = '0;
    end else if (changed) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // Capture on the edge where the count reaches the threshold, not one edge later.
    capture    = (state_q == StSettle) && sel_ok && (cnt_d == CntMax);
    frame_done = &bitmap_q;
    bitmap_d   = frame_done ? '0 : bitmap_q;
    if (capture) bitmap_d = bitmap_d | sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      seg_q          <= '0;
      an_q           <= '0;
      prev_q         <= '0;
      cnt_q          <= '0;
      bitmap_q       <= '0;
      stage_val_q    <= '0;
      stage_inv_q    <= '0;
      value_q        <= '0;
      invalid_mask_q <= '0;
      frame_err_q    <= 1'b0;
      frame_valid_q  <= 1'b0;
    end else begin
      seg_q    <= bus.seg_n;
      an_q     <= bus.an_n;
      prev_q   <= {an_q, seg_q};
      cnt_q    <= cnt_d;
      bitmap_q <= bitmap_d;

      unique case (state_q)
        StIdle:     if (sel_ok) state_q <= StSettle;
        StSettle: begin
          if (!sel_ok)      state_q <= StIdle;
          else if (capture) state_q <= StCaptured;
        end
        StCaptured: begin
          if (!sel_ok)      state_q <= StIdle;
          else if (changed) state_q <= StSettle;
        end
        default:            state_q <= StIdle;
      endcase

      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel[i]) begin
          stage_val_q[4*i +: 4] <= dec_nib;
          stage_inv_q[i]        <= dec_inv;
        end
      end

      frame_valid_q <= frame_done;
      if (frame_done) begin
        value_q        <= stage_val_q;
        invalid_mask_q <= stage_inv_q;
        frame_err_q    <= |stage_inv_q;
      end
    end
  end

  assign bus.value        = value_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.invalid_mask = invalid_mask_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans hand-built frames over the display bus.
module tb_seg7_scan_decoder;
  localparam int unsigned ND = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned fv_cnt   = 0;

  // digit 7 first: 1,2,3,4,A,B,C,D / 5,6,7,8,9,E,F,0 / 1,2,3,4,A,blank,C,D
  localparam logic [7:0][6:0] SegBasic = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [7:0][6:0] SegAlt   = {7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h06, 7'h0E, 7'h40};
  localparam logic [7:0][6:0] SegBlank = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h7F, 7'h46, 7'h21};

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS   (ND),
    .STABLE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_cnt++;

  task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg, input int unsigned n);
    bus.an_n  = an;
    bus.seg_n = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] seg, input int unsigned n);
    logic [ND-1:0] an;
    an    = '1;
    an[d] = 1'b0;
    drive(an, seg, n);
  endtask

  task automatic idle(input int unsigned n);
    drive('1, 7'h7F, n);
  endtask

  task automatic scan(input logic [7:0][6:0] segs, input int hi, input int lo,
                      input int short_d, input int unsigned short_n);
    for (int d = hi; d >= lo; d--) show(d, segs[d], (d == short_d) ? short_n : 6);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle(0);
    #1 rst_n = 1'b0;
    #12;
    n_checks++;
    if (bus.value !== 32'h0) $display("FAIL reset_value: got %h want %h", bus.value, 32'h0);
    else n_pass++;
    n_checks++;
    if (bus.frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", bus.frame_valid);
    else n_pass++;
    n_checks++;
    if (bus.frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.frame_err);
    else n_pass++;
    n_checks++;
    if (bus.invalid_mask !== 8'h00)
      $display("FAIL reset_mask: got %h want 00", bus.invalid_mask);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int unsigned fv0;
    fv0 = fv_cnt;
    scan(SegBasic, 7, 0, -1, 0);
    idle(3);
    n_checks++;
    if (fv_cnt - fv0 !== 1) $display("FAIL basic_fv_count: got %0d want 1", fv_cnt - fv0);
    else n_pass++;
    n_checks++;
    if (bus.value !== 32'h1234ABCD)
      $display("FAIL basic_value: got %h want 1234abcd", bus.value);
    else n_pass++;
    n_checks++;
    if (bus.frame_err !== 1'b0) $display("FAIL basic_err: got %b want 0", bus.frame_err);
    else n_pass++;
    n_checks++;
    if (bus.invalid_mask !== 8'h00)
      $display("FAIL basic_mask: got %h want 00", bus.invalid_mask);
    else n_pass++;
  endtask

  task automatic test_short_dwell();
    int unsigned fv0;
    fv0 = fv_cnt;
    scan(SegAlt, 7, 0, 3, 3);
    idle(3);
    n_checks++;
    if (fv_cnt != fv0) $display("FAIL short_no_fv: got %0d want 0", fv_cnt - fv0);
    else n_pass++;
    n_checks++;
    if (bus.value !== 32'h1234ABCD)
      $display("FAIL short_value_held: got %h want 1234abcd", bus.value);
    else n_pass++;
    show(3, 7'h10, 6);
    idle(3);
    n_checks++;
    if (fv_cnt - fv0 !== 1) $display("FAIL short_rescan_fv: got %0d want 1", fv_cnt - fv0);
    else n_pass++;
    n_checks++;
    if (bus.value !== 32'h56789EF0)
      $display("FAIL short_rescan_value: got %h want 56789ef0", bus.value);
    else n_pass++;
  endtask

  task automatic test_invalid();
    int unsigned fv0;
    fv0 = fv_cnt;
    scan(SegBlank, 7, 0, -1, 0);
    idle(3);
    n_checks++;
    if (fv_cnt - fv0 !== 1) $display("FAIL invalid_fv: got %0d want 1", fv_cnt - fv0);
    else n_pass++;
    n_checks++;
    if (bus.value !== 32'h1234A0CD)
      $display("FAIL invalid_value: got %h want 1234a0cd", bus.value);
    else n_pass++;
    n_checks++;
    if (bus.frame_err !== 1'b1) $display("FAIL invalid_err: got %b want 1", bus.frame_err);
    else n_pass++;
    n_checks++;
    if (bus.invalid_mask !== 8'h04)
      $display("FAIL invalid_mask: got %h want 04", bus.invalid_mask);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int unsigned fv0;
    scan(SegBasic, 7, 4, -1, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.value !== 32'h0) $display("FAIL midrst_value: got %h want 0", bus.value);
    else n_pass++;
    n_checks++;
    if (bus.frame_err !== 1'b0) $display("FAIL midrst_err: got %b want 0", bus.frame_err);
    else n_pass++;
    n_checks++;
    if (bus.invalid_mask !== 8'h00)
      $display("FAIL midrst_mask: got %h want 00", bus.invalid_mask);
    else n_pass++;
    n_checks++;
    if (bus.frame_valid !== 1'b0) $display("FAIL midrst_fv: got %b want 0", bus.frame_valid);
    else n_pass++;
    bus.an_n  = '1;
    bus.seg_n = 7'h7F;
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    fv0 = fv_cnt;
    scan(SegBasic, 3, 0, -1, 0);
    idle(3);
    n_checks++;
    if (fv_cnt != fv0) $display("FAIL midrst_partial_fv: got %0d want 0", fv_cnt - fv0);
    else n_pass++;
    n_checks++;
    if (bus.value !== 32'h0) $display("FAIL midrst_partial_value: got %h want 0", bus.value);
    else n_pass++;
    scan(SegBasic, 7, 4, -1, 0);
    idle(3);
    n_checks++;
    if (fv_cnt - fv0 !== 1) $display("FAIL midrst_full_fv: got %0d want 1", fv_cnt - fv0);
    else n_pass++;
    n_checks++;
    if (bus.value !== 32'h1234ABCD)
      $display("FAIL midrst_full_value: got %h want 1234abcd", bus.value);
    else n_pass++;
  endtask

  task automatic test_bad_select();
    int unsigned fv0;
    logic [ND-1:0] pats [2];
    pats[0] = 8'hFC;
    pats[1] = 8'hFF;
    fv0 = fv_cnt;
    for (int p = 0; p < 2; p++) begin
      drive(pats[p], 7'h79, 10);
      n_checks++;
      if (dut.cnt_q !== 3'd0) $display("FAIL badsel_cnt[%0d]: got %0d want 0", p, dut.cnt_q);
      else n_pass++;
      n_checks++;
      if (dut.bitmap_q !== 8'h00)
        $display("FAIL badsel_bitmap[%0d]: got %h want 00", p, dut.bitmap_q);
      else n_pass++;
    end
    idle(2);
    n_checks++;
    if (fv_cnt != fv0) $display("FAIL badsel_fv: got %0d want 0", fv_cnt - fv0);
    else n_pass++;
  endtask

  task automatic test_change();
    int unsigned fv0;
    fv0 = fv_cnt;
    scan(SegBasic, 7, 1, -1, 0);
    show(0, 7'h40, 2);
    show(0, 7'h79, 5);
    idle(3);
    n_checks++;
    if (fv_cnt - fv0 !== 1) $display("FAIL change_fv: got %0d want 1", fv_cnt - fv0);
    else n_pass++;
    n_checks++;
    if (bus.value !== 32'h1234ABC1)
      $display("FAIL change_value: got %h want 1234abc1", bus.value);
    else n_pass++;
    n_checks++;
    if (bus.frame_err !== 1'b0) $display("FAIL change_err: got %b want 0", bus.frame_err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned fv0;
    fv0 = fv_cnt;
    scan(SegBasic, 7, 0, -1, 0);
    scan(SegAlt, 7, 0, -1, 0);
    idle(3);
    n_checks++;
    if (fv_cnt - fv0 !== 2) $display("FAIL b2b_fv_count: got %0d want 2", fv_cnt - fv0);
    else n_pass++;
    n_checks++;
    if (bus.value !== 32'h56789EF0)
      $display("FAIL b2b_value: got %h want 56789ef0", bus.value);
    else n_pass++;
    n_checks++;
    if (bus.invalid_mask !== 8'h00)
      $display("FAIL b2b_mask: got %h want 00", bus.invalid_mask);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_dwell();
    test_invalid();
    test_mid_reset();
    test_bad_select();
    test_change();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
